exu_cal_arb: RTL
================

Name: exu_cal_arb

Overview:
- Arbitrates the shared calculation center (cal: add/sub/shift/xor/compare) between NREQ execute-stage requesters: ALU, branch compare, LSU address generation.
- Sits between the requesters and cal.
- Round-robin arbitration with a grant lock, so the presented opcode bundle stays stable while cal stalls.
- Returns the cal result to the granted requester on the handshake cycle.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 = ALU, 1 = BJP, 2 = LSU.
- OPB_W, `CIRNO_CAL_OPB_SIZE, width of one cal operation bundle (7 op bits + 2×33 operand bits).
- IDW, $clog2(NREQ), width of the requester index / pointer.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- hs_req4arb_val  in  NREQ  per-requester valid
- hs_arb4req_rdy  out  NREQ  per-requester ready (one-hot or zero)
- i_req_opb  in  NREQ*OPB_W  flattened cal bundles; requester k at bits [k*OPB_W +: OPB_W]
- o_req_res  out  32  cal result, broadcast; meaningful only where hs_arb4req_rdy is high
- hs_arb4cal_val  out  1  request to cal
- hs_cal4arb_rdy  in  1  cal ready / accept
- o_cal_opb  out  OPB_W  selected bundle, zero when hs_arb4cal_val is 0
- i_cal_res  in  32  cal result, valid in the handshake cycle
- o_grant_id  out  IDW  index currently presented to cal

Behaviour:
- Single clock domain; synchronous active-high reset.
- Registered state:
  - state: IDLE or LOCK
  - rr_ptr (IDW bits): highest-priority requester
  - lock_id (IDW bits)
- Reset (rst=1): state=IDLE, rr_ptr=0, lock_id=0. Regardless of inputs during reset: hs_arb4cal_val=0, hs_arb4req_rdy=0, o_cal_opb=0, o_req_res=0, o_grant_id=0.
- Winner selection in IDLE: the first requester with val=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, … wrapping mod NREQ). Combinational, zero-cycle path from val to cal.
- IDLE, no val: cal val=0, all rdy=0, state stays IDLE.
- IDLE, winner w, cal_rdy=1: handshake this cycle.
  - hs_arb4req_rdy[w]=1, o_req_res=i_cal_res.
  - rr_ptr ← (w+1) mod NREQ; stay IDLE.
- IDLE, winner w, cal_rdy=0:
  - cal val=1, o_cal_opb=bundle w, rdy=0.
  - lock_id ← w; state ← LOCK.
- LOCK: grant fixed to lock_id; higher-priority arrivals are ignored.
  - val[lock_id]=1 and cal_rdy=1: handshake; rr_ptr ← (lock_id+1) mod NREQ; state ← IDLE.
  - val[lock_id]=1 and cal_rdy=0: hold; o_cal_opb must remain stable.
  - val[lock_id]=0 (withdrawal, e.g. flush): cal val=0 that cycle; state ← IDLE; rr_ptr unchanged.
- Handshake invariants:
  - At most one rdy bit per cycle.
  - rdy[k]=1 only when val[k]=1 and cal_rdy=1.
  - Requesters must hold their bundle stable while val=1 and unacknowledged.
- Pointer wrap: NREQ not a power of two wraps explicitly, i.e. (NREQ-1)+1 → 0.
- Back-to-back: a new winner may handshake in the cycle after a LOCK release, with no bubble.
- Reset asserted in LOCK: returns to IDLE next edge; the pending transaction is dropped with no rdy.

Optional Feature:
- CIRNO_CAL_ARB_ALU_PRIO_EN
- Defined: in IDLE, requester 0 (ALU) wins whenever val[0]=1, regardless of rr_ptr; the others use round-robin among themselves. LOCK is unaffected, so no preemption.
- Undefined: pure round-robin for all requesters, as described above.

Decomposition:
- Shared definitions header: CIRNO_CAL_OPB_SIZE, CIRNO_CAL_* bit-field positions, requester index constants (CIRNO_CAL_REQ_ALU=0, _BJP=1, _LSU=2), state encodings (IDLE=1'b0, LOCK=1'b1).
- One natural sub-module, cal_rr_pick: combinational cyclic priority picker (val vector, pointer → winner index + any-valid flag). Reused by future arbiters.

Test Plan:
- Reset: hold rst=1 with val=3'b111 → all rdy=0, cal val=0, o_cal_opb=0. Release → first grant is id 0.
- Round-robin fairness: val=3'b111 held, cal_rdy=1 → grants 0,1,2,0 on consecutive cycles; o_req_res tracks i_cal_res each cycle.
- Lock stability: val[1] only, cal_rdy=0 for 3 cycles, val[0] asserts in cycle 2 → o_grant_id=1 and bundle stable for 3 cycles; on cal_rdy=1, rdy=3'b010; next cycle grant goes to 2 if requesting, else 0.
- Withdrawal: requester 2 locked, drops val while cal_rdy=0 → next cycle IDLE, rr_ptr unchanged; val[2] reasserted with no other requesters → re-granted id 2.
- Reset mid-LOCK: rst=1 during LOCK → no rdy pulse; after release, rr_ptr=0, state IDLE.
- Optional feature (with CIRNO_CAL_ARB_ALU_PRIO_EN): val=3'b111, cal_rdy=1 → id 0 granted every cycle; without the macro → grants 0,1,2.

Source files
------------

// File: rtl/exu_cal_arb_pkg.sv
// exu_cal_arb_pkg: shared cal bundle layout, requester indices and arbiter state encoding
package exu_cal_arb_pkg;
  localparam int CIRNO_CAL_OP_W = 7;
  localparam int CIRNO_CAL_OPND_W = 33;
  localparam int CIRNO_CAL_OPB_SIZE = CIRNO_CAL_OP_W + 2 * CIRNO_CAL_OPND_W;
  localparam int CIRNO_CAL_OPA_LSB = 0;
  localparam int CIRNO_CAL_OPB_LSB = CIRNO_CAL_OPA_LSB + CIRNO_CAL_OPND_W;
  localparam int CIRNO_CAL_OP_LSB = CIRNO_CAL_OPB_LSB + CIRNO_CAL_OPND_W;
  localparam int CIRNO_CAL_REQ_ALU = 0;
  localparam int CIRNO_CAL_REQ_BJP = 1;
  localparam int CIRNO_CAL_REQ_LSU = 2;
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/exu_cal_arb_pick.sv
// cal_rr_pick: cyclic priority picker, first set bit of val searching upward from ptr (wrapping), plus any-valid flag
module cal_rr_pick #(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  val,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] id,
  output logic          any
);
  logic [IW-1:0] idx;
  always_comb begin
    id = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (val[idx]) id = idx;
    end
    any = |val;
  end
endmodule

// File: rtl/exu_cal_arb.sv
// exu_cal_arb: round-robin arbiter with grant lock between NREQ requesters and cal (CIRNO_CAL_ARB_ALU_PRIO_EN gives ALU fixed priority in IDLE)
module exu_cal_arb
  import exu_cal_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int OPB_W = CIRNO_CAL_OPB_SIZE,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       hs_req4arb_val,
  output logic [NREQ-1:0]       hs_arb4req_rdy,
  input  logic [NREQ*OPB_W-1:0] i_req_opb,
  output logic [31:0]           o_req_res,
  output logic                  hs_arb4cal_val,
  input  logic                  hs_cal4arb_rdy,
  output logic [OPB_W-1:0]      o_cal_opb,
  input  logic [31:0]           i_cal_res,
  output logic [IDW-1:0]        o_grant_id
);
  arb_state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
  logic [IDW-1:0] rr_id, pick_id, gnt_id, nxt_ptr;
  logic [NREQ-1:0] pick_val;
  logic rr_any, pick_any, cal_val, hs;
  logic [OPB_W-1:0] opb [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_opb
    assign opb[k] = i_req_opb[k*OPB_W +: OPB_W];
  end
`ifdef CIRNO_CAL_ARB_ALU_PRIO_EN
  assign pick_val = hs_req4arb_val & ~NREQ'(1);
  assign pick_id = hs_req4arb_val[0] ? '0 : rr_id;
  assign pick_any = hs_req4arb_val[0] | rr_any;
`else
  assign pick_val = hs_req4arb_val;
  assign pick_id = rr_id;
  assign pick_any = rr_any;
`endif
  cal_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .val(pick_val),
    .ptr(rr_ptr_q),
    .id (rr_id),
    .any(rr_any)
  );
  always_comb begin
    cal_val = !rst && (state_q == LOCK ? hs_req4arb_val[lock_id_q] : pick_any);
    gnt_id = rst ? '0 : state_q == LOCK ? lock_id_q : pick_id;
    hs = cal_val && hs_cal4arb_rdy;
    nxt_ptr = gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
    hs_arb4cal_val = cal_val;
    hs_arb4req_rdy = hs ? NREQ'(1) << gnt_id : '0;
    o_req_res = hs ? i_cal_res : '0;
    o_cal_opb = cal_val ? opb[gnt_id] : '0;
    o_grant_id = gnt_id;
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      rr_ptr_d = nxt_ptr;
      state_d = IDLE;
    end else if (state_q == IDLE && cal_val) begin
      lock_id_d = gnt_id;
      state_d = LOCK;
    end else if (state_q == LOCK && !cal_val) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      lock_id_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end
endmodule
